// File: rtl/exc_arbiter.sv
// MEM-stage exception arbiter: picks the highest-priority exception/interrupt and
// drives the CP0 exception bundle plus pipeline flush/redirect. Optional: INT_SYNC_EN.
module exc_arbiter #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
   parameter int          FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic        stall_i,
   input  logic [31:0] pc_i,
   input  logic        in_delayslot_i,
   input  logic [31:0] mem_addr_i,
   input  logic        adel_if_i,
   input  logic        ri_i,
   input  logic        ov_i,
   input  logic        trap_i,
   input  logic        syscall_i,
   input  logic        break_i,
   input  logic        adel_mem_i,
   input  logic        ades_mem_i,
   input  logic        eret_i,
   input  logic [5:0]  int_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic        cp0_we_i,
   input  logic [4:0]  cp0_waddr_i,
   input  logic [31:0] cp0_wdata_i,
   output logic [31:0] excepttype_o,
   output logic [31:0] exc_pc_o,
   output logic        exc_delayslot_o,
   output logic [31:0] bad_addr_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o
);

   typedef enum logic {IDLE, FLUSH} state_t;

   localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

   // Commit protocol: an instruction is accepted only when valid_i=1 and stall_i=0
   // in IDLE; there is no back-pressure, FLUSH simply ignores valid_i.
   state_t      state_q;
   logic [1:0]  cnt_q;
   logic [31:0] excepttype_q, exc_pc_q, bad_addr_q, new_pc_q;
   logic        exc_ds_q, flush_q;

   logic [31:0] status_fwd, epc_fwd;
   logic [1:0]  cause_ip;
   logic [5:0]  int_eff;
   logic        int_pending;
   logic [31:0] code_d, bad_d, new_pc_d;
   logic        bad_upd, commit;
   logic        unused_bits;

   // An mtc0 still in WB has not reached CP0 yet, so its value wins here.
   always_comb begin
      status_fwd = cp0_status_i;
      cause_ip   = cp0_cause_i[9:8];
      epc_fwd    = cp0_epc_i;
      if (cp0_we_i) begin
         case (cp0_waddr_i)
            5'd12:   status_fwd = cp0_wdata_i;
            5'd13:   cause_ip   = cp0_wdata_i[9:8];
            5'd14:   epc_fwd    = cp0_wdata_i;
            default: ;
         endcase
      end
   end

`ifdef INT_SYNC_EN
   logic [5:0] int_s1_q, int_s2_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         int_s1_q <= '0;
         int_s2_q <= '0;
      end else begin
         int_s1_q <= int_i;
         int_s2_q <= int_s1_q;
      end
   end
   assign int_eff = int_s2_q;
`else
   assign int_eff = int_i;
`endif

   assign int_pending = status_fwd[0] & ~status_fwd[1] &
                        (|(status_fwd[15:8] & {int_eff, cause_ip}));

   always_comb begin
      code_d  = 32'h0;
      bad_d   = mem_addr_i;
      bad_upd = 1'b0;
      if (int_pending)      code_d = 32'h1;
      else if (adel_if_i) begin
         code_d  = 32'h4;
         bad_d   = pc_i;
         bad_upd = 1'b1;
      end
      else if (ri_i)        code_d = 32'hA;
      else if (ov_i)        code_d = 32'hC;
      else if (trap_i)      code_d = 32'hD;
      else if (syscall_i)   code_d = 32'h8;
      else if (break_i)     code_d = 32'h9;
      else if (adel_mem_i) begin
         code_d  = 32'h4;
         bad_upd = 1'b1;
      end
      else if (ades_mem_i) begin
         code_d  = 32'h5;
         bad_upd = 1'b1;
      end
      else if (eret_i)      code_d = 32'hE;
   end

   assign new_pc_d = (code_d == 32'hE) ? epc_fwd : EXC_VECTOR;
   assign commit   = (state_q == IDLE) && valid_i && !stall_i && (code_d != 32'h0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 2'd0;
         excepttype_q <= 32'h0;
         exc_pc_q     <= 32'h0;
         exc_ds_q     <= 1'b0;
         bad_addr_q   <= 32'h0;
         flush_q      <= 1'b0;
         new_pc_q     <= 32'h0;
      end else begin
         excepttype_q <= 32'h0;
         flush_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (commit) begin
                  state_q      <= FLUSH;
                  cnt_q        <= CNT_INIT;
                  excepttype_q <= code_d;
                  exc_pc_q     <= pc_i;
                  exc_ds_q     <= in_delayslot_i;
                  flush_q      <= 1'b1;
                  new_pc_q     <= new_pc_d;
                  if (bad_upd) bad_addr_q <= bad_d;
               end
            end
            FLUSH: begin
               // First FLUSH cycle is the one with flush_o high.
               if (cnt_q == 2'd0) state_q <= IDLE;
               else               cnt_q   <= cnt_q - 2'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign excepttype_o    = excepttype_q;
   assign exc_pc_o        = exc_pc_q;
   assign exc_delayslot_o = exc_ds_q;
   assign bad_addr_o      = bad_addr_q;
   assign flush_o         = flush_q;
   assign new_pc_o        = new_pc_q;

   assign unused_bits = ^{cp0_cause_i[31:10], cp0_cause_i[7:0],
                          status_fwd[31:16], status_fwd[7:2]};

endmodule

// File: tb/tb_exc_arbiter.sv
// Directed bench for exc_arbiter: hand-computed vectors checked with immediate
// assertions one cycle after each commit cycle.
module tb_exc_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i, stall_i, in_delayslot_i;
   logic [31:0] pc_i, mem_addr_i;
   logic        adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i;
   logic        adel_mem_i, ades_mem_i, eret_i;
   logic [5:0]  int_i;
   logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_wdata_i;
   logic        cp0_we_i;
   logic [4:0]  cp0_waddr_i;
   logic [31:0] excepttype_o, exc_pc_o, bad_addr_o, new_pc_o;
   logic        exc_delayslot_o, flush_o;

   int checks = 0;
   int errors = 0;

   exc_arbiter dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .stall_i(stall_i), .pc_i(pc_i),
      .in_delayslot_i(in_delayslot_i), .mem_addr_i(mem_addr_i),
      .adel_if_i(adel_if_i), .ri_i(ri_i), .ov_i(ov_i), .trap_i(trap_i),
      .syscall_i(syscall_i), .break_i(break_i), .adel_mem_i(adel_mem_i),
      .ades_mem_i(ades_mem_i), .eret_i(eret_i), .int_i(int_i),
      .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
      .cp0_we_i(cp0_we_i), .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
      .excepttype_o(excepttype_o), .exc_pc_o(exc_pc_o),
      .exc_delayslot_o(exc_delayslot_o), .bad_addr_o(bad_addr_o),
      .flush_o(flush_o), .new_pc_o(new_pc_o)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_flags();
      adel_if_i = 0; ri_i = 0; ov_i = 0; trap_i = 0; syscall_i = 0; break_i = 0;
      adel_mem_i = 0; ades_mem_i = 0; eret_i = 0; int_i = '0;
      cp0_we_i = 0; cp0_waddr_i = '0; cp0_wdata_i = '0;
   endtask

   initial begin
      rst = 1; valid_i = 0; stall_i = 0; in_delayslot_i = 0;
      pc_i = 32'hBFC00000; mem_addr_i = '0;
      cp0_status_i = '0; cp0_cause_i = '0; cp0_epc_i = '0;
      clear_flags();
      tick(2);
      chk("rst_type", excepttype_o, 32'h0);
      chk("rst_flush", {31'b0, flush_o}, 32'h0);
      chk("rst_newpc", new_pc_o, 32'h0);
      chk("rst_excpc", exc_pc_o, 32'h0);
      chk("rst_bad", bad_addr_o, 32'h0);
      chk("rst_ds", {31'b0, exc_delayslot_o}, 32'h0);
      rst = 0;

      // Interrupt: int_i[0] 0 -> 1 with Status=0xFF01
      cp0_status_i = 32'h0000FF01; valid_i = 1; pc_i = 32'hBFC00040;
      tick();
      chk("int_none_flush", {31'b0, flush_o}, 32'h0);
      int_i = 6'b000001;
`ifdef INT_SYNC_EN
      tick(2);
      chk("int_sync_wait", {31'b0, flush_o}, 32'h0);
`endif
      tick();
      chk("int_type", excepttype_o, 32'h1);
      chk("int_flush", {31'b0, flush_o}, 32'h1);
      chk("int_newpc", new_pc_o, 32'hBFC00380);
      chk("int_excpc", exc_pc_o, 32'hBFC00040);
      int_i = '0; valid_i = 0;
      tick();
      chk("int_pulse_end", {31'b0, flush_o}, 32'h0);
      chk("int_type_clr", excepttype_o, 32'h0);
      chk("int_newpc_hold", new_pc_o, 32'hBFC00380);
      tick(3);

      // EXL set masks the interrupt
      cp0_status_i = 32'h0000FF03; int_i = 6'b000001; valid_i = 1;
      tick(3);
      chk("int_exl_mask", {31'b0, flush_o}, 32'h0);
      int_i = '0; valid_i = 0; cp0_status_i = 32'h0000FF01;
      tick(3);

      // ov + syscall together in a delay slot: ov wins
      valid_i = 1; pc_i = 32'hBFC00100; in_delayslot_i = 1; ov_i = 1; syscall_i = 1;
      tick();
      chk("ov_type", excepttype_o, 32'hC);
      chk("ov_excpc", exc_pc_o, 32'hBFC00100);
      chk("ov_ds", {31'b0, exc_delayslot_o}, 32'h1);
      chk("ov_bad_hold", bad_addr_o, 32'h0);
      clear_flags(); valid_i = 0; in_delayslot_i = 0;
      tick();
      chk("ov_excpc_hold", exc_pc_o, 32'hBFC00100);

      // load address error then fetch address error
      valid_i = 1; pc_i = 32'hBFC00120; adel_mem_i = 1; mem_addr_i = 32'h80000003;
      tick();
      chk("adelm_type", excepttype_o, 32'h4);
      chk("adelm_bad", bad_addr_o, 32'h80000003);
      clear_flags(); valid_i = 0;
      tick();
      valid_i = 1; pc_i = 32'hBFC00200; adel_if_i = 1;
      tick();
      chk("adelif_type", excepttype_o, 32'h4);
      chk("adelif_bad", bad_addr_o, 32'hBFC00200);
      clear_flags(); valid_i = 0;
      tick();

      // store address error
      valid_i = 1; ades_mem_i = 1; mem_addr_i = 32'h80000006;
      tick();
      chk("ades_type", excepttype_o, 32'h5);
      chk("ades_bad", bad_addr_o, 32'h80000006);
      clear_flags(); valid_i = 0;
      tick();

      // ri + trap -> ri; break + eret -> break (vector redirect)
      valid_i = 1; ri_i = 1; trap_i = 1;
      tick();
      chk("ri_type", excepttype_o, 32'hA);
      clear_flags(); valid_i = 0;
      tick();
      valid_i = 1; break_i = 1; eret_i = 1; cp0_epc_i = 32'h1000;
      tick();
      chk("brk_type", excepttype_o, 32'h9);
      chk("brk_newpc", new_pc_o, 32'hBFC00380);
      clear_flags(); valid_i = 0;
      tick();

      // eret with EPC forwarded from an in-flight mtc0
      valid_i = 1; eret_i = 1; cp0_epc_i = 32'h1000;
      cp0_we_i = 1; cp0_waddr_i = 5'd14; cp0_wdata_i = 32'h2000;
      tick();
      chk("eret_type", excepttype_o, 32'hE);
      chk("eret_fwd_newpc", new_pc_o, 32'h2000);
      clear_flags(); valid_i = 0;
      tick();
      valid_i = 1; eret_i = 1; cp0_we_i = 1; cp0_waddr_i = 5'd13; cp0_wdata_i = 32'h2000;
      tick();
      chk("eret_nofwd_newpc", new_pc_o, 32'h1000);
      clear_flags(); valid_i = 0;
      tick();

      // syscall on N, N+1, N+2: commits at N and N+2 only
      valid_i = 1; syscall_i = 1; pc_i = 32'hBFC00300;
      tick();
      chk("b2b_first_flush", {31'b0, flush_o}, 32'h1);
      chk("b2b_first_type", excepttype_o, 32'h8);
      tick();
      chk("b2b_second_flush", {31'b0, flush_o}, 32'h0);
      chk("b2b_second_type", excepttype_o, 32'h0);
      tick();
      chk("b2b_third_flush", {31'b0, flush_o}, 32'h1);
      chk("b2b_third_type", excepttype_o, 32'h8);
      clear_flags(); valid_i = 0;
      tick();

      // syscall held under a 3-cycle stall, then reset during FLUSH
      valid_i = 1; syscall_i = 1; stall_i = 1; pc_i = 32'hBFC00400;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_flush", {31'b0, flush_o}, 32'h0);
      end
      stall_i = 0;
      tick();
      chk("stall_release_flush", {31'b0, flush_o}, 32'h1);
      chk("stall_release_pc", exc_pc_o, 32'hBFC00400);
      rst = 1;
      tick();
      chk("rstflush_type", excepttype_o, 32'h0);
      chk("rstflush_flush", {31'b0, flush_o}, 32'h0);
      chk("rstflush_newpc", new_pc_o, 32'h0);
      chk("rstflush_excpc", exc_pc_o, 32'h0);
      chk("rstflush_bad", bad_addr_o, 32'h0);
      chk("rstflush_ds", {31'b0, exc_delayslot_o}, 32'h0);
      rst = 0; clear_flags(); valid_i = 0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/exc_arbiter.md
Name: exc_arbiter

Overview:
- MEM-stage exception arbiter: the producer side of the CP0 exception interface.
- Collects per-instruction exception flags and the interrupt condition, and picks the highest-priority event.
- Drives the excepttype/EPC-source/bad-address bundle into CP0 for one cycle.
- Issues the pipeline flush and redirect PC (exception vector, or EPC for eret), using forwarded CP0 state.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect PC for all exceptions and interrupts.
- FLUSH_CYCLES, 1, cycles after a commit during which valid_i is ignored while the pipeline refills (1..3).

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- valid_i  in  1  MEM stage holds a live instruction
- stall_i  in  1  MEM stage stalled (memory busy); no commit while high
- pc_i  in  32  PC of the MEM instruction
- in_delayslot_i  in  1  MEM instruction is in a delay slot
- mem_addr_i  in  32  load/store effective address
- adel_if_i  in  1  fetch address error
- ri_i  in  1  reserved instruction
- ov_i  in  1  overflow
- trap_i  in  1  trap
- syscall_i  in  1  syscall
- break_i  in  1  break
- adel_mem_i  in  1  load address error
- ades_mem_i  in  1  store address error
- eret_i  in  1  eret
- int_i  in  6  hardware interrupt lines
- cp0_status_i  in  32  CP0 Status
- cp0_cause_i  in  32  CP0 Cause
- cp0_epc_i  in  32  CP0 EPC
- cp0_we_i  in  1  in-flight mtc0 write enable (WB stage)
- cp0_waddr_i  in  5  mtc0 register number
- cp0_wdata_i  in  32  mtc0 data
- excepttype_o  out  32  event code to CP0, valid one cycle
- exc_pc_o  out  32  PC of the excepting instruction, to CP0
- exc_delayslot_o  out  1  delay-slot flag, to CP0
- bad_addr_o  out  32  faulting address, to CP0
- flush_o  out  1  one-cycle flush of IF..MEM
- new_pc_o  out  32  redirect PC, valid while flush_o is high

Behaviour:
- Reset: all outputs 0; state IDLE; synchronizer flops (if present) 0. Reset mid-FLUSH returns to IDLE and clears flush_o on the next edge.
- Forwarding: if cp0_we_i is high and cp0_waddr_i is 12, use cp0_wdata_i as Status. If the address is 13, replace only Cause[9:8] with cp0_wdata_i[9:8]. If the address is 14, use cp0_wdata_i as EPC.
- Interrupt pending: Status[0]=1, Status[1]=0, and (Status[15:8] & {int, Cause[9:8]}) != 0, where int is int_i or its synchronized version.
- Commit condition: state IDLE, valid_i=1, stall_i=0, and at least one event (pending interrupt or any flag).
- Priority, highest first, with excepttype codes:
  - interrupt 0x1
  - adel_if 0x4 (bad addr = pc_i)
  - ri 0xA
  - ov 0xC
  - trap 0xD
  - syscall 0x8
  - break 0x9
  - adel_mem 0x4 (bad addr = mem_addr_i)
  - ades_mem 0x5 (bad addr = mem_addr_i)
  - eret 0xE
- Latency: outputs are registered and appear on the edge after the commit cycle, for exactly one cycle:
  - excepttype_o, exc_pc_o = pc_i, exc_delayslot_o, bad_addr_o, flush_o = 1.
  - new_pc_o = forwarded EPC for eret, EXC_VECTOR otherwise.
  - In all other cycles excepttype_o = 0, flush_o = 0, and the other outputs hold their last values.
- bad_addr_o updates only on codes 0x4 and 0x5.
- State machine:
  - IDLE to FLUSH on commit.
  - FLUSH holds for FLUSH_CYCLES cycles, counting from the cycle flush_o is high; valid_i and interrupts are ignored throughout, then back to IDLE.
  - FLUSH_CYCLES=1: back-to-back events on consecutive cycles commit only the first; the next commit is possible 2 cycles after the first.
- Stall: while stall_i=1, nothing commits; an interrupt rising during the stall is taken when the stall drops, if still pending.
- Multiple flags in one cycle: only the highest priority is reported.

Optional Feature:
- INT_SYNC_EN defined: int_i passes through a 2-flop synchronizer before the pending check, adding 2 cycles of interrupt latency.
- Undefined: int_i is used combinationally.

Test Plan:
- Status=0x0000FF01, int_i[0] 0->1, valid, no stall -> next cycle excepttype_o=0x1, flush_o=1, new_pc_o=0xBFC00380 (2 cycles later with INT_SYNC_EN).
- ov_i=1 and syscall_i=1 together, pc_i=0xBFC00100, in_delayslot_i=1 -> excepttype_o=0xC, exc_pc_o=0xBFC00100, exc_delayslot_o=1.
- adel_mem_i=1, mem_addr_i=0x80000003 -> excepttype_o=0x4, bad_addr_o=0x80000003; adel_if_i=1 instead -> bad_addr_o=pc_i.
- eret_i=1, cp0_epc_i=0x1000, cp0_we_i=1, waddr=14, wdata=0x2000 -> excepttype_o=0xE, new_pc_o=0x2000.
- syscall on cycles N and N+1 -> single flush pulse in cycle N+1; second event ignored; a new syscall at N+2 commits.
- syscall with stall_i=1 for 3 cycles -> flush_o=0 throughout; commits one cycle after stall_i drops; rst asserted in FLUSH -> all outputs 0 next edge.
